// File: rtl/shift_sequencer_pkg.sv
// Shared types for the multi-cycle shift sequencer: shift op codes and controller states.
package shift_sequencer_pkg;

  localparam int unsigned DataW = 16;

  typedef enum logic [1:0] {
    ShNone = 2'b00,
    ShLsl  = 2'b01,
    ShLsr  = 2'b10,
    ShAsr  = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational 1-bit shifter: one LSL/LSR/ASR step per evaluation, pass-through for none.
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
(
  input  logic [DataW-1:0] din,
  input  shift_op_e        shift,
  output logic [DataW-1:0] sout
);

  always_comb begin
    sout = din;
    unique case (shift)
      ShNone: sout = din;
      ShLsl:  sout = {din[DataW-2:0], 1'b0};
      ShLsr:  sout = {1'b0, din[DataW-1:1]};
      ShAsr:  sout = {din[DataW-1], din[DataW-1:1]};
      default: sout = din;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-position shift controller: applies the 1-bit shifter N times, one step per clock,
// then pulses done. Replaces a barrel shifter at the cost of N+1 cycles of latency.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [DataW-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [DataW-1:0] result
);

  state_e           state_q, state_d;
  logic [DataW-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shift_op_e        op_q, op_d;
  logic [DataW-1:0] sout;

  shift_sequencer_shifter u_shifter (
    .din   (acc_q),
    .shift (op_q),
    .sout  (sout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= ShNone;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = in;
          op_d  = shift_op_e'(op);
          cnt_d = amount;
          // Zero-length or no-op jobs skip straight to DONE with result = in.
          if (amount == '0 || shift_op_e'(op) == ShNone) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        acc_d = sout;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign result = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes expected jobs, monitor checks on done.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] result;

  shift_sequencer #(.CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amount  (amount),
    .in      (din),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          acc_cyc;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   model_free = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_shift(logic [1:0] o, int n, logic [15:0] d);
    case (o)
      2'b00:   return d;
      2'b01:   return d << n;
      2'b10:   return d >> n;
      default: return 16'($signed(d) >>> n);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One stimulus cycle; a job occupies the sequencer for n_eff+2 cycles from acceptance.
  task automatic drive_cycle(input bit s, input logic [1:0] o, input logic [3:0] a,
                             input logic [15:0] d, output bit accepted);
    int n_eff;
    exp_t e;
    @(negedge clk);
    start = s; op = o; amount = a; din = d;
    accepted = 1'b0;
    if (s && model_free <= cyc + 1) begin
      n_eff     = (o == 2'b00) ? 0 : int'(a);
      e.res     = ref_shift(o, n_eff, d);
      e.acc_cyc = cyc + 1;
      e.n       = n_eff;
      sb.push_back(e);
      model_free = cyc + 1 + n_eff + 2;
      accepted  = 1'b1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
    bit acc;
    acc = 1'b0;
    while (!acc) drive_cycle(1'b1, o, a, d, acc);
    drive_cycle(1'b0, 2'b00, 4'd0, 16'h0, acc);
  endtask

  task automatic wait_idle();
    bit acc;
    while (model_free > cyc + 1) drive_cycle(1'b0, 2'b00, 4'd0, 16'h0, acc);
  endtask

  // Monitor: pops an expectation on every done pulse.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt = 0;
      end else begin
        if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("latency", 32'(cyc - e.acc_cyc), 32'(e.n));
            check("busy_cycles", 32'(busy_cnt), 32'(e.n));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    bit acc;
    reset_n = 1'b0;
    start = 1'b0; op = 2'b00; amount = 4'd0; din = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    reset_n = 1'b1;

    issue(2'b01, 4'd4, 16'h0001);
    wait_idle();
    issue(2'b11, 4'd15, 16'h8000);
    wait_idle();
    issue(2'b10, 4'd15, 16'h8000);
    wait_idle();
    issue(2'b01, 4'd0, 16'hA5A5);
    wait_idle();
    issue(2'b00, 4'd9, 16'hA5A5);
    wait_idle();

    // Starts during a running job must be dropped.
    issue(2'b10, 4'd8, 16'hF00F);
    repeat (4) drive_cycle(1'b1, 2'b01, 4'd3, 16'h1234, acc);
    drive_cycle(1'b0, 2'b00, 4'd0, 16'h0, acc);
    wait_idle();

    // start held high: a new job every N+2 cycles.
    repeat (12) drive_cycle(1'b1, 2'b01, 4'd1, 16'h0003, acc);
    drive_cycle(1'b0, 2'b00, 4'd0, 16'h0, acc);
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 2) == 0, 2'($urandom), 4'($urandom), 16'($urandom), acc);
    end
    drive_cycle(1'b0, 2'b00, 4'd0, 16'h0, acc);
    wait_idle();

    // Reset mid-shift: outputs clear at once, job discarded, start ignored.
    issue(2'b01, 4'd15, 16'h00FF);
    repeat (3) drive_cycle(1'b0, 2'b00, 4'd0, 16'h0, acc);
    @(negedge clk);
    reset_n = 1'b0;
    start = 1'b1; op = 2'b01; amount = 4'd2; din = 16'h1111;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    check("midrun_reset_result", 32'(result), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("reset_start_ignored_busy", 32'(busy), 32'd0);
    check("reset_start_ignored_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    start = 1'b0;
    model_free = 0;
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);

    issue(2'b01, 4'd4, 16'h0001);
    repeat (20) drive_cycle(1'b0, 2'b00, 4'd0, 16'h0, acc);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
